// File: rtl/mux_sel_pipe.sv
// ============================================================================
// mux_sel_pipe : N-channel selector, registered 2-entry output buffer, valid/ready.
// Optional macro MUX_SEL_PIPE_PARITY_EN adds q_par.            Revision: 1.0
// ============================================================================
`default_nettype none

module mux_sel_pipe #(
    parameter int N     = 16,
    parameter int CH    = 16,
    parameter int SEL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH*N-1:0]   r_bus,
    input  logic [SEL_W-1:0]  selecm,
    input  logic              sel_valid,
    output logic              sel_ready,
    output logic [N-1:0]      q,
    output logic              q_err,
    output logic              q_valid,
    input  logic              q_ready
`ifdef MUX_SEL_PIPE_PARITY_EN
    ,
    output logic              q_par
`endif
);

    generate
        if ((1 << SEL_W) < CH) begin : g_sel_w_check
            $error("mux_sel_pipe: SEL_W too narrow for CH");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_skid;
    logic            r_skid_err;
    logic [N-1:0]    w_cap_data;
    logic            w_cap_err;
    logic            w_accept;
    logic            w_pop;

    // Out-of-range selects fall through to channel 0 with the error bit set.
    always_comb begin
        w_cap_data = r_bus[N-1:0];
        w_cap_err  = 1'b1;
        for (int k = 0; k < CH; k++) begin
            if (selecm == SEL_W'(k)) begin
                w_cap_data = r_bus[k*N +: N];
                w_cap_err  = 1'b0;
            end
        end
    end

    assign sel_ready = (r_state != FULL);
    assign q_valid   = (r_state != EMPTY);
    assign w_accept  = sel_valid & sel_ready;
    assign w_pop     = q_valid & q_ready;

`ifdef MUX_SEL_PIPE_PARITY_EN
    logic r_skid_par;
    logic w_cap_par;
    assign w_cap_par = ^w_cap_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            q          <= '0;
            q_err      <= 1'b0;
            r_skid     <= '0;
            r_skid_err <= 1'b0;
`ifdef MUX_SEL_PIPE_PARITY_EN
            q_par      <= 1'b0;
            r_skid_par <= 1'b0;
`endif
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        q       <= w_cap_data;
                        q_err   <= w_cap_err;
`ifdef MUX_SEL_PIPE_PARITY_EN
                        q_par   <= w_cap_par;
`endif
                        r_state <= ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        q     <= w_cap_data;
                        q_err <= w_cap_err;
`ifdef MUX_SEL_PIPE_PARITY_EN
                        q_par <= w_cap_par;
`endif
                    end else if (w_accept) begin
                        r_skid     <= w_cap_data;
                        r_skid_err <= w_cap_err;
`ifdef MUX_SEL_PIPE_PARITY_EN
                        r_skid_par <= w_cap_par;
`endif
                        r_state    <= FULL;
                    end else if (w_pop) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        q       <= r_skid;
                        q_err   <= r_skid_err;
`ifdef MUX_SEL_PIPE_PARITY_EN
                        q_par   <= r_skid_par;
`endif
                        r_state <= ONE;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mux_sel_pipe.sv
// ============================================================================
// tb_mux_sel_pipe : directed and randomized checks of mux_sel_pipe against a
// queue-based reference model.                                 Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mux_sel_pipe;

    localparam int N    = 16;
    localparam int CH   = 16;
    localparam int CH12 = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CH*N-1:0]   r_bus;
    logic [3:0]        selecm;
    logic              sel_valid, sel_ready, q_err, q_valid, q_ready;
    logic [N-1:0]      q;

    logic [CH12*N-1:0] r_bus12;
    logic [3:0]        selecm12;
    logic              sel_valid12, sel_ready12, q_err12, q_valid12, q_ready12;
    logic [N-1:0]      q12;

`ifdef MUX_SEL_PIPE_PARITY_EN
    logic q_par, q_par12;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mux_sel_pipe #(.N(N), .CH(CH), .SEL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .r_bus(r_bus), .selecm(selecm),
        .sel_valid(sel_valid), .sel_ready(sel_ready), .q(q), .q_err(q_err),
        .q_valid(q_valid), .q_ready(q_ready)
`ifdef MUX_SEL_PIPE_PARITY_EN
        , .q_par(q_par)
`endif
    );

    mux_sel_pipe #(.N(N), .CH(CH12), .SEL_W(4)) dut12 (
        .clk(clk), .rst_n(rst_n), .r_bus(r_bus12), .selecm(selecm12),
        .sel_valid(sel_valid12), .sel_ready(sel_ready12), .q(q12), .q_err(q_err12),
        .q_valid(q_valid12), .q_ready(q_ready12)
`ifdef MUX_SEL_PIPE_PARITY_EN
        , .q_par(q_par12)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [N-1:0] v);
        r_bus[k*N +: N] = v;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sel_valid = 1'b1;
        selecm    = 4'd4;
        reset_dut();
        sel_valid = 1'b0;
        checks++; if (q_valid !== 1'b0) $display("FAIL reset_q_valid: got %b expected 0", q_valid); else passes++;
        checks++; if (sel_ready !== 1'b1) $display("FAIL reset_sel_ready: got %b expected 1", sel_ready); else passes++;
        checks++; if (q !== 16'h0 || q_err !== 1'b0) $display("FAIL reset_q: got %h/%b expected 0000/0", q, q_err); else passes++;
        tick();
        checks++; if (q_valid !== 1'b0) $display("FAIL reset_req_ignored: got q_valid %b expected 0", q_valid); else passes++;
    endtask

    task automatic test_basic();
        q_ready = 1'b1;
        set_ch(5, 16'hA5A5);
        selecm = 4'd5; sel_valid = 1'b1;
        tick();
        checks++;
        if (q !== 16'hA5A5 || q_valid !== 1'b1 || q_err !== 1'b0)
            $display("FAIL basic_sel5: got %h v%b e%b expected a5a5 v1 e0", q, q_valid, q_err);
        else passes++;
        set_ch(15, 16'h1234);
        selecm = 4'd15;
        tick();
        sel_valid = 1'b0;
        checks++; if (q !== 16'h1234 || q_valid !== 1'b1) $display("FAIL basic_sel15: got %h v%b expected 1234 v1", q, q_valid); else passes++;
        tick();
        checks++; if (q_valid !== 1'b0) $display("FAIL basic_drain: got q_valid %b expected 0", q_valid); else passes++;
`ifdef MUX_SEL_PIPE_PARITY_EN
        set_ch(2, 16'h0007); selecm = 4'd2; sel_valid = 1'b1;
        tick();
        checks++; if (q_par !== 1'b1) $display("FAIL parity_7: got %b expected 1", q_par); else passes++;
        set_ch(2, 16'h0003);
        tick();
        sel_valid = 1'b0;
        checks++; if (q_par !== 1'b0) $display("FAIL parity_3: got %b expected 0", q_par); else passes++;
        tick();
`endif
    endtask

    task automatic test_capture();
        q_ready = 1'b1;
        set_ch(3, 16'h0011); selecm = 4'd3; sel_valid = 1'b1;
        tick();
        set_ch(3, 16'h0022); sel_valid = 1'b0; q_ready = 1'b0;
        tick();
        checks++; if (q !== 16'h0011 || q_valid !== 1'b1) $display("FAIL capture: got %h v%b expected 0011 v1", q, q_valid); else passes++;
        q_ready = 1'b1;
        tick();
    endtask

    task automatic test_backpressure();
        q_ready = 1'b0;
        set_ch(1, 16'h1111); set_ch(2, 16'h2222); set_ch(3, 16'h3333);
        sel_valid = 1'b1; selecm = 4'd1;
        tick();
        selecm = 4'd2;
        tick();
        selecm = 4'd3;
        checks++; if (sel_ready !== 1'b0) $display("FAIL bp_full_ready: got %b expected 0", sel_ready); else passes++;
        tick();
        checks++;
        if (sel_ready !== 1'b0 || q !== 16'h1111 || q_valid !== 1'b1)
            $display("FAIL bp_hold: got rdy%b q %h v%b expected rdy0 q 1111 v1", sel_ready, q, q_valid);
        else passes++;
        q_ready = 1'b1;
        tick();
        checks++; if (q !== 16'h2222 || sel_ready !== 1'b1) $display("FAIL bp_second: got q %h rdy%b expected 2222 rdy1", q, sel_ready); else passes++;
        tick();
        sel_valid = 1'b0;
        checks++; if (q !== 16'h3333 || q_valid !== 1'b1) $display("FAIL bp_third: got q %h v%b expected 3333 v1", q, q_valid); else passes++;
        tick();
        checks++; if (q_valid !== 1'b0) $display("FAIL bp_no_dup: got q_valid %b expected 0", q_valid); else passes++;
    endtask

    task automatic test_out_of_range();
        q_ready12 = 1'b1;
        r_bus12 = '0;
        r_bus12[N-1:0] = 16'hBEEF;
        r_bus12[11*N +: N] = 16'hCAFE;
        selecm12 = 4'd13; sel_valid12 = 1'b1;
        tick();
        checks++; if (q12 !== 16'hBEEF || q_err12 !== 1'b1) $display("FAIL oor_13: got %h e%b expected beef e1", q12, q_err12); else passes++;
        selecm12 = 4'd11;
        tick();
        checks++; if (q12 !== 16'hCAFE || q_err12 !== 1'b0) $display("FAIL oor_in_range: got %h e%b expected cafe e0", q12, q_err12); else passes++;
        selecm12 = 4'd12;
        tick();
        sel_valid12 = 1'b0;
        checks++; if (q12 !== 16'hBEEF || q_err12 !== 1'b1) $display("FAIL oor_12: got %h e%b expected beef e1", q12, q_err12); else passes++;
        tick();
    endtask

    task automatic test_stream();
        logic [N-1:0] exp_d;
        int ok = 1;
        q_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < CH; k++) set_ch(k, N'($urandom));
            selecm = 4'(i % 16); sel_valid = 1'b1;
            exp_d = r_bus[(i % 16)*N +: N];
            tick();
            if (q_valid !== 1'b1 || q !== exp_d) begin
                $display("FAIL stream_%0d: got %h v%b expected %h v1", i, q, q_valid, exp_d);
                ok = 0;
            end
        end
        sel_valid = 1'b0;
        checks++; if (ok == 1) passes++;
        tick();
    endtask

    task automatic test_reset_mid();
        q_ready = 1'b0;
        set_ch(6, 16'h6666); sel_valid = 1'b1; selecm = 4'd6;
        tick();
        tick();
        selecm = 4'd7;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; sel_valid = 1'b0; q_ready = 1'b1;
        checks++;
        if (q_valid !== 1'b0 || q !== 16'h0 || q_err !== 1'b0 || sel_ready !== 1'b1)
            $display("FAIL reset_mid: got v%b q %h e%b rdy%b expected v0 0000 e0 rdy1", q_valid, q, q_err, sel_ready);
        else passes++;
`ifdef MUX_SEL_PIPE_PARITY_EN
        checks++; if (q_par !== 1'b0) $display("FAIL reset_mid_par: got %b expected 0", q_par); else passes++;
`endif
        tick();
        checks++; if (q_valid !== 1'b0) $display("FAIL reset_mid_ignored: got q_valid %b expected 0", q_valid); else passes++;
    endtask

    task automatic test_random();
        logic [N:0] model[$];
        logic [N-1:0] d;
        logic acc, pop;
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < CH; k++) set_ch(k, N'($urandom));
            if (!(sel_valid && model.size() >= 2)) begin
                sel_valid = 1'($urandom);
                selecm    = 4'($urandom);
            end
            q_ready = ($urandom_range(0, 3) != 0);
            acc = sel_valid && (model.size() < 2);
            pop = q_ready && (model.size() > 0);
            d   = (32'(selecm) < CH) ? r_bus[32'(selecm)*N +: N] : r_bus[N-1:0];
            tick();
            if (pop) void'(model.pop_front());
            if (acc) model.push_back({1'b0, d});
            if (sel_ready !== (model.size() < 2) || q_valid !== (model.size() > 0) ||
                (model.size() > 0 && {q_err, q} !== model[0])) begin
                if (bad < 5)
                    $display("FAIL random_c%0d: got rdy%b v%b %b/%h expected depth %0d head %h",
                             c, sel_ready, q_valid, q_err, q, model.size(),
                             (model.size() > 0) ? model[0] : 17'h0);
                bad++;
            end
`ifdef MUX_SEL_PIPE_PARITY_EN
            if (model.size() > 0 && q_par !== ^model[0][N-1:0]) begin
                if (bad < 5) $display("FAIL random_par_c%0d: got %b expected %b", c, q_par, ^model[0][N-1:0]);
                bad++;
            end
`endif
        end
        checks++; if (bad == 0) passes++;
        sel_valid = 1'b0; q_ready = 1'b1;
        tick(); tick(); tick();
    endtask

    initial begin
        rst_n = 1'b0; r_bus = '0; selecm = '0; sel_valid = 1'b0; q_ready = 1'b0;
        r_bus12 = '0; selecm12 = '0; sel_valid12 = 1'b0; q_ready12 = 1'b0;
        tick(); tick();
        test_reset();
        test_basic();
        test_capture();
        test_backpressure();
        test_out_of_range();
        test_stream();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish expected finish within bound");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
